pulse_counter_capture: RTL and testbench



---
 rtl/pulse_counter_capture.sv | 132 +++++++++++++
 tb/tb_pulse_counter_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_counter_capture.sv
// Gated pulse-rate measurement.
// A two-flop synchroniser plus an edge-detect flop turns the asynchronous
// sig_in into a one-cycle rising-edge pulse. A start request opens a window
// of gate_len cycles. During the window the edges are counted into a
// saturating accumulator. When the window closes, the count is captured into
// cmpt and a one-cycle done strobe is issued.
//
// Handshake: start is a single-cycle request. It is accepted only while the
// block is idle (busy=0), which includes the done cycle. A start seen while
// busy is dropped. done is a one-cycle strobe: on that cycle cmpt/ovf
// change, and they hold until the next done.
module pulse_counter_capture #(
  parameter int WIDTH  = 8,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic [WIDTH-1:0]  cmpt,
  output logic              done,
  output logic              busy,
  output logic              ovf,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]  ACC_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [WIDTH-1:0]  cmpt_q;
  logic              done_q, busy_q, ovf_q;
  logic              pulse_edge;

  // Synchroniser and edge-detect history. This runs all the time, so the
  // edge pulse is single and never counted twice around a window boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_edge = s2_q & ~s3_q;

  // Saturating accumulator step. At the maximum value the count holds and
  // the sticky overflow flag is set instead of wrapping.
  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    if (pulse_edge) begin
      if (acc_q == ACC_MAX) begin
        ovf_acc_d = 1'b1;
      end else begin
        acc_d = acc_q + 1'b1;
      end
    end
  end

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      gate_cnt_q <= '0;
      cmpt_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (gate_len != '0) begin
              state_q    <= MEAS;
              busy_q     <= 1'b1;
              gate_cnt_q <= gate_len;
              acc_q      <= '0;
              ovf_acc_q  <= 1'b0;
            end else begin
              // An empty window completes at once with a zero count.
              done_q <= 1'b1;
              cmpt_q <= '0;
              ovf_q  <= 1'b0;
            end
          end
        end
        MEAS: begin
          gate_cnt_q <= gate_cnt_q - 1'b1;
          acc_q      <= acc_d;
          ovf_acc_q  <= ovf_acc_d;
          if (gate_cnt_q == GATE_ONE) begin
            // The last window cycle still counts its edge.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cmpt_q  <= acc_d;
            ovf_q   <= ovf_acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmpt      = cmpt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_counter_capture.sv
// Bench for pulse_counter_capture.
// The stimulus thread drives the inputs 1 ns after each rising edge. It
// pushes {done_cycle, ovf, cmpt} for every window that should complete.
// A monitor on the falling edge pops one entry for each done and compares it.
// Edge counts come from the bench's own sig_in schedule. A rise driven in
// window cycle c is seen as an edge in cycle c+2, so it is counted when
// c lies in 0..N-2.
module tb_pulse_counter_capture;

  localparam int WIDTH  = 8;
  localparam int GATE_W = 16;
  localparam int EW     = 32 + 1 + WIDTH;

  logic              clk;
  logic              rst;
  logic              sig_in;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic [WIDTH-1:0]  cmpt;
  logic              done;
  logic              busy;
  logic              ovf;
  logic              state_dbg;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_checks;
  int n_fail;
  int cyc;
  int sig_period;
  int sig_base;

  pulse_counter_capture #(.WIDTH(WIDTH), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .gate_len(gate_len),
    .cmpt(cmpt), .done(done), .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Reference: edges in an N-cycle window for the pattern
  // sig(c) = (c % p) >= p/2, which rises at c % p == p/2.
  function automatic logic [EW-1:0] model(input int t_done, input int n, input int p);
    int cnt;
    cnt = 0;
    for (int c = 0; c <= n - 2; c++) begin
      if (p != 0 && (c % p) == p / 2) cnt++;
    end
    if (cnt > (1 << WIDTH) - 1) return {32'(t_done), 1'b1, WIDTH'((1 << WIDTH) - 1)};
    return {32'(t_done), 1'b0, WIDTH'(cnt)};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sig_period != 0) sig_in = ((cyc - sig_base) % sig_period) >= (sig_period / 2);
    else sig_in = 1'b0;
  endtask

  task automatic start_win(input int n, input int p, input bit push);
    start      = 1'b1;
    gate_len   = GATE_W'(n);
    sig_period = p;
    sig_base   = cyc;
    sig_in     = 1'b0;
    if (push) exp_q.push_back(model(cyc + n + 1, n, p));
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Start a window, watch busy over it, and let the monitor check done.
  task automatic measure(input int n, input int p);
    start_win(n, p, 1'b1);
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      if (k == 1) begin
        start    = 1'b0;
        gate_len = GATE_W'($urandom_range(1, 65535));
      end
      check("busy_window", 64'(busy), 64'(k <= n));
    end
    sig_period = 0;
    wait_drain(10);
    idle(5);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got done with cmpt %0d, required no done", cyc, cmpt);
      end else begin
        exp_e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(exp_e[EW-1:WIDTH+1]));
        check("cmpt", 64'(cmpt), 64'(exp_e[WIDTH-1:0]));
        check("ovf", 64'(ovf), 64'(exp_e[WIDTH]));
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    sig_period = 0;
    sig_base   = 0;
    rst        = 1'b1;
    sig_in     = 1'b0;
    start      = 1'b0;
    gate_len   = '0;
    idle(3);
    rst = 1'b0;

    // Idle outputs hold with no start for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_cmpt", 64'(cmpt), 0);
      check("idle_done", 64'(done), 0);
      check("idle_busy", 64'(busy), 0);
      check("idle_ovf", 64'(ovf), 0);
      check("idle_state", 64'(state_dbg), 0);
    end

    // N=100, period 8: rises at 4,12,..,92 -> 12 edges.
    measure(100, 8);
    // Empty window: done next cycle, zero count, busy stays low.
    measure(0, 0);
    // N=1000, period 2: 499 edges -> saturates at 255 with ovf.
    measure(1000, 2);
    // Quiet follow-up clears cmpt and ovf.
    measure(20, 0);

    // Start while busy is ignored. A start in the done cycle is accepted.
    // With N=50 and period 8, rises at 4..44 -> 6 edges in each window.
    start_win(50, 8, 1'b1);
    for (int k = 1; k <= 51; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 10) begin
        start    = 1'b1;
        gate_len = GATE_W'(5);
      end
      if (k == 11) start = 1'b0;
      check("busy_restart", 64'(busy), 64'(k <= 50));
      if (k == 51) start_win(50, 8, 1'b1);
    end
    for (int k = 1; k <= 51; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      check("busy_back2back", 64'(busy), 64'(k <= 50));
    end
    sig_period = 0;
    wait_drain(10);
    idle(5);

    // Reset 30 cycles into a 100-cycle window: no done for that window.
    start_win(100, 8, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    rst        = 1'b1;
    sig_period = 0;
    sig_in     = 1'b0;
    #1;
    check("rst_cmpt", 64'(cmpt), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ovf", 64'(ovf), 0);
    check("rst_state", 64'(state_dbg), 0);
    idle(3);
    rst = 1'b0;
    idle(10);
    // Normal measurement after reset: N=20, period 4 -> rises 2..18 -> 5.
    measure(20, 4);

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
